// File: rtl/seed_a_storage_sched.sv
// seed_a_storage_sched
//   Shares the 128-bit seed_A storage between one writer (SHAKE squeeze or
//   pk unpacker) and two readers (matrix-A generator, pk packer). Arbitrates
//   requests, issues the direction command to the storage, routes the 64-bit
//   word stream of the granted requester and tracks whether a complete seed
//   is held.
//
//   Ports
//     clk, rst                  clock, asynchronous active-low reset
//     wr_*                      writer request/grant and word stream into storage
//     rd0_*, rd1_*              reader request/grant and word streams out of storage
//     st_cmd*                   direction command to storage (1 = store in, 0 = read out)
//     st_in*                    word stream towards the storage
//     st_out*                   word stream from the storage
//     seedValid                 storage holds a completely written seed
//     busy                      scheduler is not idle
//     err                       sticky: storage last flag disagreed with the word count
//
//   state | meaning
//   IDLE  | no owner; arbitrate wr > readers (readers only with a valid seed)
//   CMD   | owner latched; direction command offered to the storage
//   XFER  | words pass combinationally between owner and storage

module seed_a_storage_sched #(
    parameter int WORDS = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        wr_req,
    output logic        wr_gnt,
    input  logic [63:0] wr_data,
    input  logic        wr_isReady,
    output logic        wr_canReceive,
    output logic        wr_isLast,

    input  logic        rd0_req,
    output logic        rd0_gnt,
    output logic [63:0] rd0_data,
    output logic        rd0_isReady,
    input  logic        rd0_canReceive,
    output logic        rd0_isLast,

    input  logic        rd1_req,
    output logic        rd1_gnt,
    output logic [63:0] rd1_data,
    output logic        rd1_isReady,
    input  logic        rd1_canReceive,
    output logic        rd1_isLast,

    output logic        st_cmd,
    output logic        st_cmd_isReady,
    input  logic        st_cmd_canReceive,

    output logic [63:0] st_in,
    output logic        st_in_isReady,
    input  logic        st_in_canReceive,
    input  logic        st_in_isLast,

    input  logic [63:0] st_out,
    input  logic        st_out_isReady,
    output logic        st_out_canReceive,
    input  logic        st_out_isLast,

    output logic        seedValid,
    output logic        busy,
    output logic        err
);

    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_XFER} state_t;
    typedef enum logic [1:0] {OWN_WR, OWN_RD0, OWN_RD1} owner_t;

    state_t         state_q, state_d;
    owner_t         owner_q, owner_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           seed_valid_q, seed_valid_d;
    logic           err_q, err_d;
    // 1 = rd1 was served last, so rd0 wins the next tie (reset value)
    logic           last_rd1_q, last_rd1_d;

    logic           in_xfer;
    logic           own_wr, own_rd0, own_rd1;
    logic           cnt_last;
    logic           rd_take;
    logic           xfer_hs;
    logic           st_last_flag;

    assign in_xfer      = (state_q == S_XFER);
    assign own_wr       = (owner_q == OWN_WR);
    assign own_rd0      = (owner_q == OWN_RD0);
    assign own_rd1      = (owner_q == OWN_RD1);
    assign cnt_last     = (cnt_q == LAST_CNT);
    assign rd_take      = (own_rd0 & rd0_canReceive) | (own_rd1 & rd1_canReceive);
    assign xfer_hs      = in_xfer & (own_wr ? (wr_isReady & st_in_canReceive)
                                            : (st_out_isReady & rd_take));
    assign st_last_flag = own_wr ? st_in_isLast : st_out_isLast;

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_WR;
            cnt_q        <= '0;
            seed_valid_q <= 1'b0;
            err_q        <= 1'b0;
            last_rd1_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            seed_valid_q <= seed_valid_d;
            err_q        <= err_d;
            last_rd1_q   <= last_rd1_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        seed_valid_d = seed_valid_q;
        err_d        = err_q;
        last_rd1_d   = last_rd1_q;
        case (state_q)
            S_IDLE: begin
                if (wr_req) begin
                    state_d      = S_CMD;
                    owner_d      = OWN_WR;
                    // contents become stale the moment a rewrite is granted
                    seed_valid_d = 1'b0;
                end else if (seed_valid_q && (rd0_req || rd1_req)) begin
                    state_d = S_CMD;
                    if (rd0_req && rd1_req)
                        owner_d = last_rd1_q ? OWN_RD0 : OWN_RD1;
                    else if (rd0_req)
                        owner_d = OWN_RD0;
                    else
                        owner_d = OWN_RD1;
                end
            end
            S_CMD: begin
                if (st_cmd_canReceive) begin
                    state_d = S_XFER;
                    cnt_d   = '0;
                end
            end
            S_XFER: begin
                if (xfer_hs) begin
                    cnt_d = cnt_q + CW'(1);
                    if (st_last_flag != cnt_last)
                        err_d = 1'b1;
                    if (cnt_last) begin
                        state_d = S_IDLE;
                        if (own_wr)
                            seed_valid_d = 1'b1;
                        else
                            last_rd1_d = own_rd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // outputs; data buses are plain pass-through, qualified only by isReady
    assign st_in     = wr_data;
    assign rd0_data  = st_out;
    assign rd1_data  = st_out;
    assign seedValid = seed_valid_q;
    assign err       = err_q;

    always_comb begin
        busy              = (state_q != S_IDLE);
        wr_gnt            = busy & own_wr;
        rd0_gnt           = busy & own_rd0;
        rd1_gnt           = busy & own_rd1;
        st_cmd_isReady    = (state_q == S_CMD);
        st_cmd            = (state_q == S_CMD) & own_wr;
        wr_canReceive     = 1'b0;
        wr_isLast         = 1'b0;
        st_in_isReady     = 1'b0;
        rd0_isReady       = 1'b0;
        rd0_isLast        = 1'b0;
        rd1_isReady       = 1'b0;
        rd1_isLast        = 1'b0;
        st_out_canReceive = 1'b0;
        if (in_xfer) begin
            case (owner_q)
                OWN_WR: begin
                    st_in_isReady = wr_isReady;
                    wr_canReceive = st_in_canReceive;
                    wr_isLast     = cnt_last;
                end
                OWN_RD0: begin
                    rd0_isReady       = st_out_isReady;
                    st_out_canReceive = rd0_canReceive;
                    rd0_isLast        = cnt_last;
                end
                OWN_RD1: begin
                    rd1_isReady       = st_out_isReady;
                    st_out_canReceive = rd1_canReceive;
                    rd1_isLast        = cnt_last;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seed_a_storage_sched.sv
module tb_seed_a_storage_sched;

    localparam logic [63:0] W0 = 64'h0123456789ABCDEF;
    localparam logic [63:0] W1 = 64'hFEDCBA9876543210;
    localparam logic [63:0] W2 = 64'hA5A5A5A5C3C3C3C3;
    localparam logic [63:0] W3 = 64'h5A5A5A5A3C3C3C3C;

    logic        clk, rst;
    logic        wr_req, wr_gnt, wr_isReady, wr_canReceive, wr_isLast;
    logic [63:0] wr_data;
    logic        rd0_req, rd0_gnt, rd0_isReady, rd0_canReceive, rd0_isLast;
    logic [63:0] rd0_data;
    logic        rd1_req, rd1_gnt, rd1_isReady, rd1_canReceive, rd1_isLast;
    logic [63:0] rd1_data;
    logic        st_cmd, st_cmd_isReady, st_cmd_canReceive;
    logic [63:0] st_in;
    logic        st_in_isReady, st_in_canReceive, st_in_isLast;
    logic [63:0] st_out;
    logic        st_out_isReady, st_out_canReceive, st_out_isLast;
    logic        seedValid, busy, err;

    int total = 0;
    int bad   = 0;

    seed_a_storage_sched #(.WORDS(2)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_data(wr_data), .wr_isReady(wr_isReady),
        .wr_canReceive(wr_canReceive), .wr_isLast(wr_isLast),
        .rd0_req(rd0_req), .rd0_gnt(rd0_gnt), .rd0_data(rd0_data), .rd0_isReady(rd0_isReady),
        .rd0_canReceive(rd0_canReceive), .rd0_isLast(rd0_isLast),
        .rd1_req(rd1_req), .rd1_gnt(rd1_gnt), .rd1_data(rd1_data), .rd1_isReady(rd1_isReady),
        .rd1_canReceive(rd1_canReceive), .rd1_isLast(rd1_isLast),
        .st_cmd(st_cmd), .st_cmd_isReady(st_cmd_isReady), .st_cmd_canReceive(st_cmd_canReceive),
        .st_in(st_in), .st_in_isReady(st_in_isReady), .st_in_canReceive(st_in_canReceive),
        .st_in_isLast(st_in_isLast),
        .st_out(st_out), .st_out_isReady(st_out_isReady), .st_out_canReceive(st_out_canReceive),
        .st_out_isLast(st_out_isLast),
        .seedValid(seedValid), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        wr_req = 0; wr_data = '0; wr_isReady = 0;
        rd0_req = 0; rd0_canReceive = 0;
        rd1_req = 0; rd1_canReceive = 0;
        st_cmd_canReceive = 1; st_in_canReceive = 1; st_in_isLast = 0;
        st_out = '0; st_out_isReady = 0; st_out_isLast = 0;
        repeat (2) tick();
        chk("rst_wr_gnt", wr_gnt, 0);
        chk("rst_rd0_gnt", rd0_gnt, 0);
        chk("rst_rd1_gnt", rd1_gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_seedValid", seedValid, 0);
        chk("rst_err", err, 0);
        chk("rst_cmd_rdy", st_cmd_isReady, 0);
        chk("rst_out_canrx", st_out_canReceive, 0);
        rst = 1'b1;

        // reader blocked without a valid seed
        rd0_req = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("noseed_rd0_gnt", rd0_gnt, 0);
            chk("noseed_busy", busy, 0);
        end
        rd0_req = 0;

        // first write
        wr_req = 1;
        tick();
        chk("w1_gnt", wr_gnt, 1);
        chk("w1_cmd_rdy", st_cmd_isReady, 1);
        chk("w1_cmd", st_cmd, 1);
        chk("w1_busy", busy, 1);
        wr_req = 0; wr_data = W0; wr_isReady = 1; st_in_isLast = 0;
        #1;
        chk("w1_cmd_canrx", wr_canReceive, 0);
        chk("w1_cmd_in_rdy", st_in_isReady, 0);
        tick();
        chk("w1_d0", st_in, W0);
        chk("w1_d0_rdy", st_in_isReady, 1);
        chk("w1_d0_canrx", wr_canReceive, 1);
        chk("w1_d0_last", wr_isLast, 0);
        tick();
        wr_data = W1; st_in_isLast = 1;
        #1;
        chk("w1_d1", st_in, W1);
        chk("w1_d1_last", wr_isLast, 1);
        chk("w1_d1_valid", seedValid, 0);
        chk("w1_d1_gnt", wr_gnt, 1);
        tick();
        wr_isReady = 0; st_in_isLast = 0;
        chk("w1_done_gnt", wr_gnt, 0);
        chk("w1_done_valid", seedValid, 1);
        chk("w1_done_err", err, 0);
        chk("w1_done_busy", busy, 0);

        // both readers: rd0 first, then rd1 after one idle cycle
        rd0_req = 1; rd1_req = 1;
        tick();
        chk("r0_gnt", rd0_gnt, 1);
        chk("r0_rd1_gnt", rd1_gnt, 0);
        chk("r0_cmd", st_cmd, 0);
        chk("r0_cmd_rdy", st_cmd_isReady, 1);
        rd0_req = 0; st_out = W0; st_out_isReady = 1; st_out_isLast = 0; rd0_canReceive = 1;
        #1;
        chk("r0_cmd_isrdy", rd0_isReady, 0);
        tick();
        chk("r0_d0", rd0_data, W0);
        chk("r0_d0_rdy", rd0_isReady, 1);
        chk("r0_d0_canrx", st_out_canReceive, 1);
        chk("r0_d0_last", rd0_isLast, 0);
        chk("r0_d0_rd1rdy", rd1_isReady, 0);
        tick();
        st_out = W1; st_out_isLast = 1;
        #1;
        chk("r0_d1", rd0_data, W1);
        chk("r0_d1_last", rd0_isLast, 1);
        tick();
        st_out_isReady = 0; st_out_isLast = 0; rd0_canReceive = 0;
        chk("r0_idle_gnt0", rd0_gnt, 0);
        chk("r0_idle_gnt1", rd1_gnt, 0);
        chk("r0_idle_busy", busy, 0);
        tick();
        chk("r1_gnt", rd1_gnt, 1);
        chk("r1_rd0_gnt", rd0_gnt, 0);
        rd1_req = 0; st_out = W0; st_out_isReady = 1; rd1_canReceive = 1;
        tick();
        chk("r1_d0", rd1_data, W0);
        chk("r1_d0_rdy", rd1_isReady, 1);
        chk("r1_d0_rd0rdy", rd0_isReady, 0);
        chk("r1_d0_last", rd1_isLast, 0);
        tick();
        st_out = W1; st_out_isLast = 1;
        #1;
        chk("r1_d1", rd1_data, W1);
        chk("r1_d1_last", rd1_isLast, 1);
        tick();
        st_out_isReady = 0; st_out_isLast = 0; rd1_canReceive = 0;
        chk("r1_done_gnt", rd1_gnt, 0);
        chk("r1_done_err", err, 0);

        // writer beats a simultaneous reader
        wr_req = 1; rd1_req = 1;
        tick();
        chk("w2_gnt", wr_gnt, 1);
        chk("w2_rd1_gnt", rd1_gnt, 0);
        chk("w2_valid_clr", seedValid, 0);
        wr_req = 0; wr_data = W2; wr_isReady = 1;
        tick();
        chk("w2_d0", st_in, W2);
        tick();
        wr_data = W3; st_in_isLast = 1;
        #1;
        chk("w2_d1_valid", seedValid, 0);
        tick();
        wr_isReady = 0; st_in_isLast = 0;
        chk("w2_done_valid", seedValid, 1);
        chk("w2_done_rd1_gnt", rd1_gnt, 0);
        tick();
        chk("r1b_gnt", rd1_gnt, 1);
        rd1_req = 0; st_out = W2; st_out_isReady = 1; rd1_canReceive = 1;
        tick();
        chk("r1b_d0", rd1_data, W2);
        tick();
        st_out = W3; st_out_isLast = 1;
        tick();
        st_out_isReady = 0; st_out_isLast = 0; rd1_canReceive = 0;
        chk("r1b_done_gnt", rd1_gnt, 0);

        // rd0 back-pressure 1-0-1
        rd0_req = 1;
        tick();
        chk("rt_gnt", rd0_gnt, 1);
        rd0_req = 0; st_out = W2; st_out_isReady = 1; st_out_isLast = 0; rd0_canReceive = 1;
        tick();
        chk("rt_d0", rd0_data, W2);
        tick();
        st_out = W3; st_out_isLast = 1; rd0_canReceive = 0;
        #1;
        chk("rt_stall_canrx", st_out_canReceive, 0);
        chk("rt_stall_last", rd0_isLast, 1);
        tick();
        rd0_canReceive = 1;
        #1;
        chk("rt_resume_gnt", rd0_gnt, 1);
        chk("rt_resume_last", rd0_isLast, 1);
        chk("rt_resume_d1", rd0_data, W3);
        chk("rt_resume_canrx", st_out_canReceive, 1);
        tick();
        st_out_isReady = 0; st_out_isLast = 0; rd0_canReceive = 0;
        chk("rt_done_gnt", rd0_gnt, 0);
        chk("rt_done_err", err, 0);

        // tie after rd0 served: rd1 wins; rd0 withdraws; wrong storage last flags
        rd0_req = 1; rd1_req = 1;
        tick();
        chk("tie_rd1_gnt", rd1_gnt, 1);
        chk("tie_rd0_gnt", rd0_gnt, 0);
        rd0_req = 0; rd1_req = 0;
        st_out = W0; st_out_isReady = 1; st_out_isLast = 1; rd1_canReceive = 1;
        tick();
        chk("e_pre_err", err, 0);
        tick();
        st_out = W1; st_out_isLast = 0;
        #1;
        chk("e_err_set", err, 1);
        tick();
        st_out_isReady = 0; rd1_canReceive = 0;
        chk("e_err_sticky", err, 1);
        chk("e_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("withdrawn_rd0_gnt", rd0_gnt, 0);
        end

        // reset in the middle of a write
        wr_req = 1;
        tick();
        wr_req = 0; wr_data = W0; wr_isReady = 1; st_in_isLast = 0;
        tick();
        tick();
        wr_data = W1; st_in_isLast = 1;
        #1;
        chk("ar_pre_gnt", wr_gnt, 1);
        rst = 1'b0;
        #1;
        chk("ar_gnt", wr_gnt, 0);
        chk("ar_busy", busy, 0);
        chk("ar_in_rdy", st_in_isReady, 0);
        chk("ar_canrx", wr_canReceive, 0);
        chk("ar_last", wr_isLast, 0);
        chk("ar_valid", seedValid, 0);
        chk("ar_err", err, 0);
        chk("ar_cmd_rdy", st_cmd_isReady, 0);
        wr_isReady = 0; st_in_isLast = 0;
        tick();
        rst = 1'b1;
        rd0_req = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ar_blk_rd0_gnt", rd0_gnt, 0);
            chk("ar_blk_busy", busy, 0);
        end
        rd0_req = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seed_a_storage_sched.md
# seed_a_storage_sched

Scheduler that shares the 128-bit seed_A storage between one writer and two readers. The writer is the SHAKE squeeze or the pk unpacker; the readers are the matrix-A generator and the pk packer. It arbitrates requests, issues the one-bit start command to the storage (1 = store in, 0 = read out) and routes the 64-bit word streams of the granted requester. It also tracks whether the storage holds a valid seed.

## Interface
- WORDS, 2: words per transaction (128-bit seed / 64-bit bus); counter width is clog2(WORDS), minimum 1.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- wr_req  in  1  writer request; hold until wr_gnt.
- wr_gnt  out  1  writer owns the storage.
- wr_data  in  64  writer word.
- wr_isReady  in  1  wr_data valid.
- wr_canReceive  out  1  word accepted.
- wr_isLast  out  1  current word is the last.
- rd0_req, rd1_req  in  1  reader requests; hold until granted.
- rd0_gnt, rd1_gnt  out  1  reader owns the storage.
- rd0_data, rd1_data  out  64  read word.
- rd0_isReady, rd1_isReady  out  1  word valid.
- rd0_canReceive, rd1_canReceive  in  1  reader takes word.
- rd0_isLast, rd1_isLast  out  1  last word.
- st_cmd  out  1  storage command, 1 = in, 0 = out.
- st_cmd_isReady  out  1  command valid.
- st_cmd_canReceive  in  1  storage accepts command.
- st_in  out  64  word to storage.
- st_in_isReady  out  1  valid.
- st_in_canReceive  in  1  accept.
- st_in_isLast  in  1  storage's last flag.
- st_out  in  64  word from storage.
- st_out_isReady  in  1  valid.
- st_out_canReceive  out  1  accept.
- st_out_isLast  in  1  last.
- seedValid  out  1  storage holds a completely written seed.
- busy  out  1  state != IDLE.
- err  out  1  sticky: storage isLast disagrees with the internal word count.

## Operation
- States: IDLE, CMD, XFER.
- IDLE: arbitrate on registered inputs.
  - Priority: wr_req first.
  - Readers are eligible only when seedValid=1. If both are eligible, grant the reader not served last (lastRd register; reset value selects rd0 first).
  - On a grant, latch the owner and the direction, then go to CMD.
- CMD: st_cmd_isReady=1 and st_cmd = (owner==wr).
  - On st_cmd_canReceive, go to XFER and clear the word counter.
  - A writer grant clears seedValid on entry to CMD.
- XFER, write owner: st_in=wr_data, st_in_isReady=wr_isReady, wr_canReceive=st_in_canReceive.
- XFER, read owner: rdN_data=st_out, rdN_isReady=st_out_isReady, st_out_canReceive=rdN_canReceive.
- All other requester handshake outputs are 0. Non-owner data outputs carry st_out but are qualified only by isReady.
- Handshake: valid and accept high in the same cycle.
  - Each handshake increments the counter.
  - isLast to the requester is (counter==WORDS-1).
  - If the storage isLast differs from this on a handshake, set err.
- On the handshake where counter==WORDS-1: go to IDLE and drop the grant. A write also sets seedValid; a read updates lastRd.
- A requester dropping req mid-transaction is ignored; completion happens only via data handshakes.
- A request withdrawn while in IDLE before a grant is simply not granted.

## Timing
- Reset (async assert, sync release): state IDLE, all gnt=0, st_cmd_isReady=0, all isReady/canReceive=0, seedValid=0, err=0, busy=0, lastRd selects rd0 next.
  - The storage contents are not reset; seedValid=0 makes them unreadable.
- Request sampled in IDLE at edge t: gnt and st_cmd_isReady are high from t+1.
- Data paths are combinational pass-through in XFER, so there is zero added latency per word and full throughput of one word per cycle.
- After the last handshake at edge t, gnt is low from t+1, and there is a minimum of one IDLE cycle before the next grant, which can be at t+1 in IDLE.
- A back-to-back transaction takes 1 IDLE + 1 CMD (if accepted immediately) + WORDS cycles.
- Reset mid-XFER: immediate abort to the reset values. The storage must share the same rst so its serdes also aborts.

## Test plan
- Reset, then rd0_req=1: no grant for 20 cycles while seedValid=0, and busy=0.
- wr_req with words 0x0123456789ABCDEF then 0xFEDCBA9876543210: wr_gnt at t+1; st_cmd=1 is accepted; wr_isLast rises on word 2 only; seedValid=1 the cycle after; err=0.
- rd0_req and rd1_req together after the write: rd0 is served first and receives the two words in order; rd1 follows after one IDLE cycle with the same data.
- wr_req and rd1_req simultaneous with seedValid=1: the writer is granted first, and seedValid=0 during the write.
- rd0_canReceive toggling 1-0-1 during a read: no word is lost or duplicated, and the grant drops after the second handshake.
- rst asserted mid-XFER after word 1 of a write: all outputs take their reset values asynchronously, and the next read is blocked because seedValid=0.
